edge_detect_accel: RTL and testbench
====================================

// Module: edge_detect_accel
// PURPOSE
//  Memory-mapped Sobel edge-detection accelerator for RGB images stored one pixel per 32-bit word.
//  A slave register port accepts image size, source base and destination base. Writing the
//  destination base starts a job. A master port reads source pixels and writes (W-2)x(H-2) edge pixels.
// PARAMETERS
//  THRESH   8'd128  binarisation threshold (used only when EDGE_THRESHOLD_EN is defined)
//  MAX_DIM  16'd2500  largest legal width/height; a start with a larger value is ignored
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous active-high reset
//  s_haddr    in   32  slave register address (word index; bits [1:0] used)
//  s_hwrite   in   1   slave write (address phase)
//  s_hwdata   in   32  slave write data (data phase)
//  s_hrdata   out  32  slave read data (data phase)
//  s_hready   out  1   slave ready; always 1
//  m_haddr    out  32  master pixel address (word index)
//  m_hwrite   out  1   1 = write request, 0 = read / idle
//  m_hwdata   out  32  master write data {8'h00,v,v,v}
//  m_hrdata   in   32  read pixel {b0,b1,b2,8'hxx} in [31:8]
//  m_hready   in   1   memory completes the current transfer this cycle
// BEHAVIOUR
//  Reset: all registers 0; s_hrdata=0; s_hready=1; m_haddr=0; m_hwrite=0; m_hwdata=0; FSM=IDLE.
//  Slave port (AHB-style pipelined):
//   - s_haddr/s_hwrite are latched every cycle. A write commits at the end of the following data phase.
//   - Read data is combinational from the latched address and the current registers.
//  Register map:
//   - 0 W: {WIDTH[31:16],HEIGHT[15:0]}; R: status, 32'hFFFF_FFFF busy / 0 idle.
//   - 1 R/W: RBASE.  2 R/W: WBASE.  3: reads 0.
//  Start: a write commit to reg 2 while IDLE with 3<=W,H<=MAX_DIM sets busy.
//   - Busy is visible in the immediately following data phase.
//   - Register writes while busy are ignored.
//  Master handshake:
//   - The DUT drives m_haddr/m_hwrite/m_hwdata and holds them stable until a cycle with m_hready=1.
//   - On a read, m_hrdata is sampled in that cycle. On a write, the write completes in that cycle.
//   - No transfer is outstanding in IDLE. When idle, m_haddr holds its last value and m_hwrite=0.
//   - Two consecutive reads never use the same address.
//  Addresses:
//   - Source pixel (x,y) = RBASE + y*W + x.
//   - Output pixel (x,y), x<W-2 and y<H-2, = WBASE + y*(W-2) + x, written in row-major order.
//  FSM: IDLE -> RD0 -> RD1 -> RD2 -> (col>=2 ? CALC -> WR : RD0) ... -> IDLE.
//   - RD0/1/2 read rows y,y+1,y+2 of column col and shift them into a 3x3 window.
//   - CALC registers the result (1 cycle). WR writes output (col-2,y).
//   - After col=W-1: y++ and col=0. The job ends after WR of (W-3,H-3); busy clears and the FSM returns to IDLE.
//  Arithmetic:
//   - gray = (b0 + 2*b1 + b2) >> 2, 10-bit sum.
//   - Gx = right column - left column, Gy = bottom row - top row, weights 1,2,1; signed 12-bit.
//   - mag = |Gx|+|Gy| saturated to 255. v = mag.
//  rst asserted mid-job aborts it: outputs return to reset values next cycle and no further transfers occur.
// CONFIGURATION
//  EDGE_THRESHOLD_EN defined:   v = (mag >= THRESH) ? 8'hFF : 8'h00.
//  EDGE_THRESHOLD_EN undefined: v = saturated mag. THRESH is unused.
// STRUCTURE
//  Package edge_pkg: register indices (REG_DIM=0, REG_RBASE=1, REG_WBASE=2), BUSY_WORD, state enum, pixel typedefs.
//  Sub-module sobel_kernel: combinational 3x3 gray window -> 8-bit v. Includes the threshold option.
//  Top level: slave regs, FSM, window shift registers, address counters.
// TESTING
//  Setup for all tests: memory model asserts m_hready one cycle after each new request.
//  T1 config: write {5,4}, RBASE=1, WBASE=200000 -> next reg0 read 32'hFFFF_FFFF; s_hready always 1.
//  T2 uniform image 5x4, all 0x808080 -> exactly 6 writes, to 200000..200005, data 0; then status 0.
//  T3 5x3 step, cols 0-1 = 0x000000, cols 2-4 = 0xFFFFFF (no threshold) -> writes 0x00FFFFFF, 0x00FFFFFF, 0x00000000.
//  T4 back-pressure: m_hready delayed 3 cycles -> m_haddr/m_hwrite/m_hwdata stable; output identical to T3.
//  T5 reg writes during busy (W=9) -> ignored; job completes with the original config.
//  T6 rst mid-job -> m_hwrite=0, status reads 0, no further transfers.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the Sobel edge-detection accelerator: register map, FSM states,
// pixel/window types and the RGB-to-gray helper.
package edge_pkg;

  localparam logic [1:0]  REG_DIM   = 2'd0;
  localparam logic [1:0]  REG_RBASE = 2'd1;
  localparam logic [1:0]  REG_WBASE = 2'd2;
  localparam logic [31:0] BUSY_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StCalc,
    StWr
  } state_e;

  typedef logic [7:0]  gray_t;
  typedef logic [31:0] word_t;
  // [row][col], row 0 = top, col 0 = left
  typedef gray_t [2:0][2:0] window_t;

  // Pixel word carries {b0,b1,b2} in [31:8]; low byte is don't-care.
  function automatic gray_t gray_of(input word_t px);
    logic [9:0] sum;
    sum = {2'b00, px[31:24]} + {1'b0, px[23:16], 1'b0} + {2'b00, px[15:8]};
    return sum[9:2];
  endfunction

  function automatic logic dim_ok(input logic [15:0] d, input logic [15:0] max_dim);
    return (d >= 16'd3) && (d <= max_dim);
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel operator over a 3x3 gray window producing one 8-bit output value.
// Define EDGE_THRESHOLD_EN to binarise the saturated magnitude against THRESH.
module sobel_kernel
  import edge_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd128
) (
  input  window_t i_win,
  output gray_t   o_v
);

  logic signed [11:0] w_gx;
  logic signed [11:0] w_gy;
  logic [10:0]        w_ax;
  logic [10:0]        w_ay;
  logic [11:0]        w_mag;
  gray_t              w_mag_sat;

  function automatic logic signed [11:0] wsum(input gray_t a, input gray_t b, input gray_t c);
    return $signed({4'b0000, a}) + $signed({3'b000, b, 1'b0}) + $signed({4'b0000, c});
  endfunction

  always_comb begin
    w_gx = wsum(i_win[0][2], i_win[1][2], i_win[2][2]) -
           wsum(i_win[0][0], i_win[1][0], i_win[2][0]);
    w_gy = wsum(i_win[2][0], i_win[2][1], i_win[2][2]) -
           wsum(i_win[0][0], i_win[0][1], i_win[0][2]);
    // |G| never exceeds 1020, so 11 magnitude bits are enough
    w_ax = w_gx[11] ? (~w_gx[10:0] + 11'd1) : w_gx[10:0];
    w_ay = w_gy[11] ? (~w_gy[10:0] + 11'd1) : w_gy[10:0];
    w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    w_mag_sat = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
  end

`ifdef EDGE_THRESHOLD_EN
  assign o_v = (w_mag >= {4'b0000, THRESH}) ? 8'hFF : 8'h00;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^THRESH;
  assign o_v = w_mag_sat;
`endif

endmodule

// File: rtl/edge_detect_accel.sv
// Memory-mapped Sobel accelerator: slave register port, column-scanning read FSM and edge writer.
// Define EDGE_THRESHOLD_EN to emit binarised (0x00/0xFF) edge values instead of magnitudes.
module edge_detect_accel
  import edge_pkg::*;
#(
  parameter logic [7:0]  THRESH  = 8'd128,
  parameter logic [15:0] MAX_DIM = 16'd2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_haddr,
  input  logic        s_hwrite,
  input  logic [31:0] s_hwdata,
  output logic [31:0] s_hrdata,
  output logic        s_hready,
  output logic [31:0] m_haddr,
  output logic        m_hwrite,
  output logic [31:0] m_hwdata,
  input  logic [31:0] m_hrdata,
  input  logic        m_hready
);

  logic [1:0] r_haddr;
  logic       r_hwrite;
  word_t      r_dim, r_rbase, r_wbase;
  state_e     r_state, w_state_next;
  logic [15:0] r_col, w_col_next, r_y, w_y_next;
  word_t      r_row_addr, w_row_addr_next, r_out_addr, w_out_addr_next;
  word_t      r_m_haddr, w_m_haddr_next, r_m_hwdata, w_m_hwdata_next;
  logic       r_m_hwrite, w_m_hwrite_next;
  gray_t      r_top, r_mid;
  window_t    r_win;

  logic [15:0] w_width, w_height;
  word_t      w_width32, w_col32;
  logic       w_idle, w_start;
  gray_t      w_v;
  logic       w_unused;

  assign w_width   = r_dim[31:16];
  assign w_height  = r_dim[15:0];
  assign w_width32 = {16'h0000, w_width};
  assign w_col32   = {16'h0000, r_col};
  assign w_idle    = (r_state == StIdle);
  assign w_start   = r_hwrite && w_idle && (r_haddr == REG_WBASE) &&
                     dim_ok(w_width, MAX_DIM) && dim_ok(w_height, MAX_DIM);
  assign w_unused  = ^{s_haddr[31:2], m_hrdata[7:0]};

  assign s_hready = 1'b1;
  assign m_haddr  = r_m_haddr;
  assign m_hwrite = r_m_hwrite;
  assign m_hwdata = r_m_hwdata;

  always_comb begin
    s_hrdata = '0;
    case (r_haddr)
      REG_DIM:   s_hrdata = w_idle ? 32'h0 : BUSY_WORD;
      REG_RBASE: s_hrdata = r_rbase;
      REG_WBASE: s_hrdata = r_wbase;
      default:   s_hrdata = '0;
    endcase
  end

  sobel_kernel #(
    .THRESH(THRESH)
  ) u_kernel (
    .i_win(r_win),
    .o_v  (w_v)
  );

  always_comb begin
    w_state_next    = r_state;
    w_col_next      = r_col;
    w_y_next        = r_y;
    w_row_addr_next = r_row_addr;
    w_out_addr_next = r_out_addr;
    w_m_haddr_next  = r_m_haddr;
    w_m_hwrite_next = r_m_hwrite;
    w_m_hwdata_next = r_m_hwdata;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next    = StRd0;
          w_col_next      = '0;
          w_y_next        = '0;
          w_row_addr_next = r_rbase;
          w_out_addr_next = s_hwdata;
          w_m_haddr_next  = r_rbase;
          w_m_hwrite_next = 1'b0;
        end
      end
      StRd0: begin
        if (m_hready) begin
          w_state_next   = StRd1;
          w_m_haddr_next = r_row_addr + w_width32 + w_col32;
        end
      end
      StRd1: begin
        if (m_hready) begin
          w_state_next   = StRd2;
          w_m_haddr_next = r_row_addr + {w_width32[30:0], 1'b0} + w_col32;
        end
      end
      StRd2: begin
        if (m_hready) begin
          if (r_col >= 16'd2) begin
            w_state_next = StCalc;
          end else begin
            w_state_next   = StRd0;
            w_col_next     = r_col + 16'd1;
            w_m_haddr_next = r_row_addr + w_col32 + 32'd1;
          end
        end
      end
      StCalc: begin
        w_state_next    = StWr;
        w_m_haddr_next  = r_out_addr;
        w_m_hwrite_next = 1'b1;
        w_m_hwdata_next = {8'h00, w_v, w_v, w_v};
      end
      StWr: begin
        if (m_hready) begin
          w_out_addr_next = r_out_addr + 32'd1;
          w_m_hwrite_next = 1'b0;
          if (r_col == w_width - 16'd1) begin
            if (r_y == w_height - 16'd3) begin
              w_state_next = StIdle;
            end else begin
              // next band starts one source row lower, back at column 0
              w_state_next    = StRd0;
              w_y_next        = r_y + 16'd1;
              w_col_next      = '0;
              w_row_addr_next = r_row_addr + w_width32;
              w_m_haddr_next  = r_row_addr + w_width32;
            end
          end else begin
            w_state_next   = StRd0;
            w_col_next     = r_col + 16'd1;
            w_m_haddr_next = r_row_addr + w_col32 + 32'd1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_dim      <= '0;
      r_rbase    <= '0;
      r_wbase    <= '0;
      r_state    <= StIdle;
      r_col      <= '0;
      r_y        <= '0;
      r_row_addr <= '0;
      r_out_addr <= '0;
      r_m_haddr  <= '0;
      r_m_hwrite <= 1'b0;
      r_m_hwdata <= '0;
      r_top      <= '0;
      r_mid      <= '0;
      r_win      <= '0;
    end else begin
      r_haddr  <= s_haddr[1:0];
      r_hwrite <= s_hwrite;
      if (r_hwrite && w_idle) begin
        case (r_haddr)
          REG_DIM:   r_dim   <= s_hwdata;
          REG_RBASE: r_rbase <= s_hwdata;
          REG_WBASE: r_wbase <= s_hwdata;
          default: ;
        endcase
      end
      r_state    <= w_state_next;
      r_col      <= w_col_next;
      r_y        <= w_y_next;
      r_row_addr <= w_row_addr_next;
      r_out_addr <= w_out_addr_next;
      r_m_haddr  <= w_m_haddr_next;
      r_m_hwrite <= w_m_hwrite_next;
      r_m_hwdata <= w_m_hwdata_next;
      if (r_state == StRd0 && m_hready) r_top <= gray_of(m_hrdata);
      if (r_state == StRd1 && m_hready) r_mid <= gray_of(m_hrdata);
      if (r_state == StRd2 && m_hready) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_top;
        r_win[1][2] <= r_mid;
        r_win[2][2] <= gray_of(m_hrdata);
      end
    end
  end

endmodule

// File: tb/tb_edge_detect_accel.sv
// Directed and randomized bench for edge_detect_accel with a word-addressed memory model
// and a loop-based Sobel reference.
module tb_edge_detect_accel;

  logic        clk, rst;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hready;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic        m_hwrite, m_hready;

  edge_detect_accel dut (
    .clk     (clk),
    .rst     (rst),
    .s_haddr (s_haddr),
    .s_hwrite(s_hwrite),
    .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata),
    .s_hready(s_hready),
    .m_haddr (m_haddr),
    .m_hwrite(m_hwrite),
    .m_hwdata(m_hwdata),
    .m_hrdata(m_hrdata),
    .m_hready(m_hready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_a[$], log_d[$], exp_a[$], exp_d[$];
  int mem_delay = 1;
  int cnt = 0;
  int viol = 0;
  logic [64:0] last_req;

  // Memory: a request is a new (addr,write,data) triple; ready comes mem_delay cycles later.
  always @(negedge clk) begin
    logic [64:0] req;
    req = {m_haddr, m_hwrite, m_hwdata};
    if (rst) begin
      cnt = 0;
      last_req = req;
      m_hready = 1'b0;
    end else begin
      if (req !== last_req) begin
        if (!m_hready) viol++;
        cnt = 0;
      end else begin
        cnt++;
      end
      last_req = req;
      m_hready = (cnt >= mem_delay);
      m_hrdata = mem.exists(m_haddr) ? mem[m_haddr] : 32'h0;
      if (m_hready && cnt == mem_delay && m_hwrite) begin
        log_a.push_back(m_haddr);
        log_d.push_back(m_hwdata);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    s_haddr = {30'h0, a}; s_hwrite = 1'b1;
    @(posedge clk); #1;
    s_hwrite = 1'b0; s_haddr = 32'h0; s_hwdata = d;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    s_haddr = {30'h0, a}; s_hwrite = 1'b0;
    @(posedge clk); #1;
    d = s_hrdata;
  endtask

  task automatic fill(input int w, input int h, input logic [31:0] rb, input int mode,
                      input logic [23:0] val);
    logic [31:0] px;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (mode)
          0:       px = {val, 8'h3C};
          1:       px = (x >= 2) ? 32'hFFFF_FF00 : 32'h0000_00A5;
          default: px = $urandom();
        endcase
        mem[rb + 32'(y * w + x)] = px;
      end
    end
  endtask

  task automatic model(input int w, input int h, input logic [31:0] rb, input logic [31:0] wb);
    int g[3][3];
    int gx, gy, mag;
    logic [31:0] px;
    logic [7:0] v;
    exp_a.delete(); exp_d.delete();
    for (int y = 0; y < h - 2; y++) begin
      for (int x = 0; x < w - 2; x++) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            px = mem[rb + 32'((y + r) * w + x + c)];
            g[r][c] = (int'(px[31:24]) + 2 * int'(px[23:16]) + int'(px[15:8])) / 4;
          end
        end
        gx = (g[0][2] - g[0][0]) + 2 * (g[1][2] - g[1][0]) + (g[2][2] - g[2][0]);
        gy = (g[2][0] - g[0][0]) + 2 * (g[2][1] - g[0][1]) + (g[2][2] - g[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
`ifdef EDGE_THRESHOLD_EN
        v = (mag >= 128) ? 8'hFF : 8'h00;
`else
        v = 8'(mag);
`endif
        exp_a.push_back(wb + 32'(y * (w - 2) + x));
        exp_d.push_back({8'h00, v, v, v});
      end
    end
  endtask

  task automatic begin_job(input string tag, input int w, input int h,
                           input logic [31:0] rb, input logic [31:0] wb);
    model(w, h, rb, wb);
    log_a.delete(); log_d.delete(); viol = 0;
    wr(2'd0, {w[15:0], h[15:0]});
    wr(2'd1, rb);
    s_haddr = 32'h2; s_hwrite = 1'b1;
    @(posedge clk); #1;
    s_hwrite = 1'b0; s_haddr = 32'h0; s_hwdata = wb;
    @(posedge clk); #1;
    check({tag, "_busy"}, s_hrdata, 32'hFFFF_FFFF);
    check({tag, "_hready"}, {31'h0, s_hready}, 32'h1);
  endtask

  task automatic finish_job(input string tag);
    logic [31:0] d;
    bit done;
    int n;
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      rd(2'd0, d);
      if (d == 32'h0) done = 1;
    end
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check({tag, "_count"}, log_a.size(), exp_a.size());
    n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_a[i], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), log_d[i], exp_d[i]);
    end
    check({tag, "_stable"}, viol, 0);
  endtask

  initial begin
    logic [31:0] d;
    int w, h, n;
    rst = 1'b1; s_haddr = '0; s_hwrite = 1'b0; s_hwdata = '0;
    m_hready = 1'b0; m_hrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_haddr", m_haddr, 32'h0);
    check("rst_hwrite", {31'h0, m_hwrite}, 32'h0);
    check("rst_hwdata", m_hwdata, 32'h0);
    check("rst_hrdata", s_hrdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1/T2: uniform grey image -> zero edges everywhere
    fill(5, 4, 32'd1, 0, 24'h808080);
    begin_job("t1", 5, 4, 32'd1, 32'd200000);
    rd(2'd1, d);
    check("t1_rbase", d, 32'd1);
    finish_job("t2");
    check("t2_n6", log_a.size(), 6);
    if (log_a.size() == 6) begin
      check("t2_first", log_a[0], 32'd200000);
      check("t2_last", log_a[5], 32'd200005);
    end
    rd(2'd0, d);
    check("t2_status", d, 32'h0);

    // T3: vertical step edge
    fill(5, 3, 32'd1000, 1, 24'h0);
    begin_job("t3", 5, 3, 32'd1000, 32'd200000);
    finish_job("t3");
    if (log_d.size() == 3) begin
      check("t3_d0", log_d[0], 32'h00FF_FFFF);
      check("t3_d1", log_d[1], 32'h00FF_FFFF);
      check("t3_d2", log_d[2], 32'h0000_0000);
    end

    // T4: same image under back-pressure
    mem_delay = 3;
    begin_job("t4", 5, 3, 32'd1000, 32'd200000);
    finish_job("t4");
    mem_delay = 1;

    // Smallest legal image
    fill(3, 3, 32'd2000, 2, 24'h0);
    begin_job("min", 3, 3, 32'd2000, 32'd210000);
    finish_job("min");

    // Randomized images and latencies
    for (int k = 0; k < 4; k++) begin
      w = $urandom_range(3, 8);
      h = $urandom_range(3, 6);
      mem_delay = $urandom_range(1, 2);
      fill(w, h, 32'd3000 + 32'(k * 100), 2, 24'h0);
      begin_job($sformatf("rnd%0d", k), w, h, 32'd3000 + 32'(k * 100), 32'd220000 + 32'(k * 100));
      finish_job($sformatf("rnd%0d", k));
    end
    mem_delay = 1;

    // Out-of-range dimensions must not start a job
    wr(2'd0, {16'd2, 16'd5});
    wr(2'd2, 32'd230000);
    rd(2'd0, d);
    check("bad_w2", d, 32'h0);
    wr(2'd0, {16'd2501, 16'd3});
    wr(2'd2, 32'd230000);
    rd(2'd0, d);
    check("bad_w2501", d, 32'h0);
    wr(2'd0, {16'd3, 16'd2501});
    wr(2'd2, 32'd230000);
    rd(2'd0, d);
    check("bad_h2501", d, 32'h0);

    // T5: register writes during busy are ignored
    fill(9, 4, 32'd5000, 2, 24'h0);
    begin_job("t5", 9, 4, 32'd5000, 32'd240000);
    wr(2'd0, {16'd4, 16'd3});
    wr(2'd1, 32'h5555);
    wr(2'd2, 32'h7777);
    finish_job("t5");
    rd(2'd1, d);
    check("t5_rbase", d, 32'd5000);
    rd(2'd2, d);
    check("t5_wbase", d, 32'd240000);

    // T6: reset mid-job
    fill(7, 5, 32'd6000, 2, 24'h0);
    begin_job("t6", 7, 5, 32'd6000, 32'd250000);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("t6_hwrite", {31'h0, m_hwrite}, 32'h0);
    check("t6_haddr", m_haddr, 32'h0);
    check("t6_hwdata", m_hwdata, 32'h0);
    rst = 1'b0;
    n = log_a.size();
    repeat (50) @(posedge clk);
    #1;
    check("t6_nowrites", log_a.size(), n);
    check("t6_haddr_hold", m_haddr, 32'h0);
    rd(2'd0, d);
    check("t6_status", d, 32'h0);
    rd(2'd1, d);
    check("t6_rbase", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
